ov5640_crop_wr: RTL
===================

Name: ov5640_crop_wr

Overview:
- Downstream of the OV5640 byte-to-RGB565 assembler; runs in the camera pixel clock domain.
- Consumes the assembled 16-bit pixel stream (write enable plus pixel) and the camera vsync.
- Tracks pixel x/y position per frame and forwards only a rectangular region of interest to the write port of the external async FIFO feeding the SDRAM writer.
- Provides frame start/done pulses, per-frame error reporting and overflow-drop handling.

Parameters:
IMG_W, 640, active pixels per line from the assembler
IMG_H, 480, active lines per frame
CROP_X0, 0, first forwarded column
CROP_Y0, 0, first forwarded line
CROP_W, 640, forwarded columns; CROP_X0+CROP_W <= IMG_W
CROP_H, 480, forwarded lines; CROP_Y0+CROP_H <= IMG_H

Ports:
ov5640_pclk  in  1  pixel clock, rising edge
sys_rst_n  in  1  asynchronous active-low reset
ov5640_vsync  in  1  camera vsync, high during sync; a rising edge marks the frame boundary
pix_wr_en  in  1  one-cycle strobe, one assembled pixel valid
pix_data  in  16  RGB565 pixel, valid with pix_wr_en
fifo_full  in  1  downstream FIFO cannot accept a write this cycle
fifo_wr_en  out  1  write strobe to the FIFO
fifo_wr_data  out  16  pixel to the FIFO
frame_start  out  1  one-cycle pulse at each accepted frame boundary
frame_done  out  1  one-cycle pulse with the last cropped pixel write
frame_err  out  1  one-cycle pulse: the previous frame's pixel count was not IMG_W*IMG_H
frame_ovf  out  1  sticky: the current frame was truncated by fifo_full; cleared at next frame_start
drop_cnt  out  8  frames truncated since reset, saturates at 255

Behaviour:
- Reset (async, sys_rst_n low): all outputs 0; state WAIT_VS; x/y counters 0; vsync delay flop 0.
- Vsync is registered once; vs_rise = vsync_q & ~vsync_d.
- FSM states:
  - WAIT_VS: ignore pixels until the first vs_rise, then go to ACTIVE and pulse frame_start the following cycle.
  - ACTIVE: count and forward pixels.
  - DROP: count pixels, forward none.
  - DROP goes to ACTIVE on the next vs_rise.
- Frame boundary (vs_rise in ACTIVE or DROP):
  - Reset x and y to 0; clear frame_ovf.
  - Pulse frame_start.
  - Pulse frame_err if the pixels counted since the last boundary != IMG_W*IMG_H.
  - Both pulses are registered, so they appear 1 cycle after vs_rise.
- Counting, on every pix_wr_en outside WAIT_VS:
  - x increments and wraps at IMG_W-1 to 0; y increments on each x wrap.
  - After the pixel at (IMG_W-1, IMG_H-1), set a saturated flag. Further pixels are not forwarded and force frame_err at the next boundary.
- Forwarding:
  - A pixel is in the crop if CROP_X0 <= x < CROP_X0+CROP_W and CROP_Y0 <= y < CROP_Y0+CROP_H.
  - In ACTIVE, an in-crop pixel with fifo_full=0 drives fifo_wr_en=1 and fifo_wr_data=pix_data on the next cycle (latency 1).
  - fifo_wr_data holds its last value when fifo_wr_en=0.
- Overflow:
  - An in-crop pixel in ACTIVE with fifo_full=1 is not written.
  - State goes to DROP, frame_ovf is set, and drop_cnt increments with saturation.
  - The rest of that frame is discarded and frame_done is not pulsed for it.
- frame_done: pulses in the same cycle as the fifo_wr_en for pixel (CROP_X0+CROP_W-1, CROP_Y0+CROP_H-1).
- Simultaneous vs_rise and pix_wr_en in one cycle: the boundary wins and the pixel is discarded.
- Counters sized by clog2 of IMG_W and IMG_H; the total-pixel counter is sized by clog2(IMG_W*IMG_H+1) and saturates.
- fifo_full is sampled only in the same cycle as pix_wr_en; no combinational path from fifo_full to outputs.

Decomposition:
- Shared package ov5640_pkg: FSM state enum (WAIT_VS, ACTIVE, DROP), RGB565 pixel typedef, default IMG_W/IMG_H constants shared with the assembler.
- One natural sub-module, ov5640_pos_cnt: x/y/total counters with wrap, saturation and in-crop compare.
- The FSM and output registers stay in the top module.

Test Plan:
- Basic crop (IMG_W=8, IMG_H=4, CROP 2,1,4,2), one full frame, pix_data = 0..31: exactly 8 writes, data 10,11,12,13,18,19,20,21; frame_done aligned with the write of 21; no frame_err.
- Pre-sync pixels: 5 pix_wr_en before the first vsync edge produce no writes and no frame_start. The first vs_rise produces frame_start one cycle later.
- Short frame: 30 pixels, then vs_rise. Expect a frame_err pulse 1 cycle after vs_rise; the next full 32-pixel frame produces no frame_err.
- Overflow: fifo_full=1 during the 3rd in-crop pixel. Expect only 2 writes, frame_ovf=1, drop_cnt=1, no frame_done. The next frame resumes with 8 writes and frame_ovf is cleared at frame_start.
- Collision: vs_rise in the same cycle as pix_wr_en. The pixel is not counted and the new frame's x/y start at 0. Also assert sys_rst_n low mid-frame: all outputs go to 0 immediately and the block waits for the next vs_rise.

Source files
------------

// File: rtl/ov5640_pkg.sv
// Shared types and default geometry for the OV5640 capture path.
// Used by the byte assembler and the crop/writer stage.
package ov5640_pkg;

  localparam int IMG_W_DEF = 640;
  localparam int IMG_H_DEF = 480;

  typedef logic [15:0] rgb565_t;

  typedef enum logic [1:0] {
    WAIT_VS = 2'd0,
    ACTIVE  = 2'd1,
    DROP    = 2'd2
  } crop_state_t;

endpackage

// File: rtl/ov5640_pos_cnt.sv
// Per-frame pixel position tracker: x/y with wrap, saturating total count, crop window compare.
// Registered counters, combinational in_crop/crop_last/cnt_err on the current position.
module ov5640_pos_cnt
  import ov5640_pkg::*;
#(
  parameter int IMG_W   = IMG_W_DEF,
  parameter int IMG_H   = IMG_H_DEF,
  parameter int CROP_X0 = 0,
  parameter int CROP_Y0 = 0,
  parameter int CROP_W  = IMG_W_DEF,
  parameter int CROP_H  = IMG_H_DEF
) (
  input  logic ov5640_pclk,
  input  logic sys_rst_n,
  input  logic clr,
  input  logic inc,
  output logic in_crop,
  output logic crop_last,
  output logic sat,
  output logic cnt_err
);

  localparam int XW   = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int YW   = (IMG_H > 1) ? $clog2(IMG_H) : 1;
  localparam int NPIX = IMG_W * IMG_H;
  localparam int TW   = $clog2(NPIX + 1);

  localparam logic [XW-1:0] X_LAST  = XW'(IMG_W - 1);
  localparam logic [YW-1:0] Y_LAST  = YW'(IMG_H - 1);
  localparam logic [XW-1:0] CX0     = XW'(CROP_X0);
  localparam logic [YW-1:0] CY0     = YW'(CROP_Y0);
  localparam logic [XW-1:0] CX_LAST = XW'(CROP_X0 + CROP_W - 1);
  localparam logic [YW-1:0] CY_LAST = YW'(CROP_Y0 + CROP_H - 1);
  localparam logic [TW-1:0] T_FULL  = TW'(NPIX);
  localparam logic [XW:0]   CW      = (XW+1)'(CROP_W);
  localparam logic [YW:0]   CH      = (YW+1)'(CROP_H);

  logic [XW-1:0] x;
  logic [YW-1:0] y;
  logic [TW-1:0] tot;
  logic          over;
  logic [XW:0]   x_off;
  logic [YW:0]   y_off;

  // Offsets below the window origin wrap past CROP_W/CROP_H, so one compare covers both bounds.
  assign x_off     = {1'b0, x} - {1'b0, CX0};
  assign y_off     = {1'b0, y} - {1'b0, CY0};
  assign in_crop   = (x_off < CW) && (y_off < CH);
  assign crop_last = (x == CX_LAST) && (y == CY_LAST);
  assign cnt_err   = (tot != T_FULL) || over;

  always_ff @(posedge ov5640_pclk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      x    <= '0;
      y    <= '0;
      tot  <= '0;
      sat  <= 1'b0;
      over <= 1'b0;
    end else if (clr) begin
      x    <= '0;
      y    <= '0;
      tot  <= '0;
      sat  <= 1'b0;
      over <= 1'b0;
    end else if (inc) begin
      if (sat) begin
        over <= 1'b1;
      end else begin
        if (tot != T_FULL) tot <= tot + 1'b1;
        // Position freezes on the last pixel of the frame; extra pixels only mark the overrun.
        if (x == X_LAST) begin
          if (y == Y_LAST) begin
            sat <= 1'b1;
          end else begin
            x <= '0;
            y <= y + 1'b1;
          end
        end else begin
          x <= x + 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/ov5640_crop_wr.sv
// Forwards a rectangular ROI of the assembled RGB565 stream to the SDRAM-side async FIFO, latency 1.
// fifo_full on an in-crop pixel drops the rest of the frame until the next vsync edge.
module ov5640_crop_wr
  import ov5640_pkg::*;
#(
  parameter int IMG_W   = IMG_W_DEF,
  parameter int IMG_H   = IMG_H_DEF,
  parameter int CROP_X0 = 0,
  parameter int CROP_Y0 = 0,
  parameter int CROP_W  = IMG_W_DEF,
  parameter int CROP_H  = IMG_H_DEF
) (
  input  logic        ov5640_pclk,
  input  logic        sys_rst_n,
  input  logic        ov5640_vsync,
  input  logic        pix_wr_en,
  input  logic [15:0] pix_data,
  input  logic        fifo_full,
  output logic        fifo_wr_en,
  output logic [15:0] fifo_wr_data,
  output logic        frame_start,
  output logic        frame_done,
  output logic        frame_err,
  output logic        frame_ovf,
  output logic [7:0]  drop_cnt
);

  crop_state_t state, state_nxt;
  logic        vsync_q, vsync_d, vs_rise;
  logic        pix_go, fwd, wr_go, ovf_hit, boundary;
  logic        in_crop, crop_last, sat, cnt_err;

  always_ff @(posedge ov5640_pclk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      vsync_q <= 1'b0;
      vsync_d <= 1'b0;
    end else begin
      vsync_q <= ov5640_vsync;
      vsync_d <= vsync_q;
    end
  end

  assign vs_rise = vsync_q & ~vsync_d;

  ov5640_pos_cnt #(
    .IMG_W   (IMG_W),
    .IMG_H   (IMG_H),
    .CROP_X0 (CROP_X0),
    .CROP_Y0 (CROP_Y0),
    .CROP_W  (CROP_W),
    .CROP_H  (CROP_H)
  ) u_pos_cnt (
    .ov5640_pclk (ov5640_pclk),
    .sys_rst_n   (sys_rst_n),
    .clr         (vs_rise),
    .inc         (pix_go),
    .in_crop     (in_crop),
    .crop_last   (crop_last),
    .sat         (sat),
    .cnt_err     (cnt_err)
  );

  always_ff @(posedge ov5640_pclk or negedge sys_rst_n) begin
    if (!sys_rst_n) state <= WAIT_VS;
    else            state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      WAIT_VS: if (vs_rise) state_nxt = ACTIVE;
      ACTIVE: begin
        if (vs_rise)      state_nxt = ACTIVE;
        else if (ovf_hit) state_nxt = DROP;
      end
      DROP:    if (vs_rise) state_nxt = ACTIVE;
      default: state_nxt = WAIT_VS;
    endcase
  end

  // A pixel coinciding with the frame boundary is discarded, not counted.
  always_comb begin
    boundary = vs_rise && (state != WAIT_VS);
    pix_go   = pix_wr_en && !vs_rise && (state != WAIT_VS);
    fwd      = pix_go && (state == ACTIVE) && in_crop && !sat;
    wr_go    = fwd && !fifo_full;
    ovf_hit  = fwd && fifo_full;
  end

  always_ff @(posedge ov5640_pclk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      fifo_wr_en   <= 1'b0;
      fifo_wr_data <= '0;
      frame_start  <= 1'b0;
      frame_done   <= 1'b0;
      frame_err    <= 1'b0;
      frame_ovf    <= 1'b0;
      drop_cnt     <= '0;
    end else begin
      fifo_wr_en  <= wr_go;
      frame_done  <= wr_go && crop_last;
      frame_start <= vs_rise;
      frame_err   <= boundary && cnt_err;
      if (wr_go) fifo_wr_data <= pix_data;
      if (vs_rise)      frame_ovf <= 1'b0;
      else if (ovf_hit) frame_ovf <= 1'b1;
      if (ovf_hit && (drop_cnt != 8'hff)) drop_cnt <= drop_cnt + 8'd1;
    end
  end

endmodule
